// File: rtl/mmult_host_if.sv
// rtl/mmult_host_if.sv - byte-in / entry-out streams plus multiplier-side bus for mmult_host
//
// Signals:
//   in_valid/in_ready/in_data        operand byte stream into the host
//   mm_reset_n/mm_enable             control to the matrix multiplier
//   A_mat/B_mat [0:71]               operand matrices (row-major, 9 x 8 bits)
//   mm_valid/C_mat [0:152]           multiplier result (9 x 17 bits)
//   out_valid/out_ready/out_data/out_last  result entry stream
// Modports: slave = the host block itself, master = its environment.

interface mmult_host_if;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;

    logic          mm_reset_n;
    logic          mm_enable;
    logic [0:71]   A_mat;
    logic [0:71]   B_mat;
    logic          mm_valid;
    logic [0:152]  C_mat;

    logic          out_valid;
    logic          out_ready;
    logic [16:0]   out_data;
    logic          out_last;

    modport slave (
        input  in_valid, in_data, mm_valid, C_mat, out_ready,
        output in_ready, mm_reset_n, mm_enable, A_mat, B_mat,
               out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, mm_valid, C_mat, out_ready,
        input  in_ready, mm_reset_n, mm_enable, A_mat, B_mat,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/mmult_host.sv
// rtl/mmult_host.sv - host sequencer: loads A/B bytes, runs the multiplier, drains 9 C entries
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      mmult_host_if.slave (byte input, multiplier control/result, entry output)
//   busy     high in every state except LOAD
//   err      sticky timeout flag (constant 0 unless MMULT_HOST_TIMEOUT_EN)
// Optional feature: define MMULT_HOST_TIMEOUT_EN to build the WAIT timeout and ERR state,
// limited by parameter TIMEOUT_CYCLES.

module mmult_host #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    mmult_host_if.slave  bus,
    output logic         busy,
    output logic         err
);

`ifdef MMULT_HOST_TIMEOUT_EN
    typedef enum logic [2:0] {S_LOAD, S_RST, S_WAIT, S_DRAIN, S_ERR} state_t;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
`else
    typedef enum logic [2:0] {S_LOAD, S_RST, S_WAIT, S_DRAIN} state_t;
    // The limit only matters in the timeout build.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    state_t        state_q, state_d;
    logic [4:0]    byte_cnt_q, byte_cnt_d;
    logic [3:0]    ent_cnt_q, ent_cnt_d;
    logic [0:71]   a_q, a_d;
    logic [0:71]   b_q, b_d;
    logic [0:152]  c_q, c_d;
    // Low during the cycle after a reset edge so in_ready/mm_reset_n stay low then.
    logic          alive_q;

    logic          in_fire;
    logic [6:0]    a_off;
    logic [6:0]    b_off;
    logic [7:0]    c_off;

    assign in_fire = bus.in_valid && alive_q && (state_q == S_LOAD);
    assign a_off   = {byte_cnt_q[3:0], 3'b000};
    assign b_off   = {4'(byte_cnt_q - 5'd9), 3'b000};
    assign c_off   = {ent_cnt_q, 4'b0000} + {4'b0000, ent_cnt_q};   // ent * 17

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_LOAD;
            byte_cnt_q <= '0;
            ent_cnt_q  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            alive_q    <= 1'b0;
`ifdef MMULT_HOST_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            ent_cnt_q  <= ent_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            alive_q    <= 1'b1;
`ifdef MMULT_HOST_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        ent_cnt_d  = ent_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
`ifdef MMULT_HOST_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    if (byte_cnt_q < 5'd9) begin
                        a_d[a_off +: 8] = bus.in_data;
                    end else begin
                        b_d[b_off +: 8] = bus.in_data;
                    end
                    if (byte_cnt_q == 5'd17) begin
                        byte_cnt_d = '0;
                        state_d    = S_RST;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end
            end
            S_RST: begin
                state_d = S_WAIT;
`ifdef MMULT_HOST_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (bus.mm_valid) begin
                    c_d       = bus.C_mat;
                    ent_cnt_d = '0;
                    state_d   = S_DRAIN;
                end
`ifdef MMULT_HOST_TIMEOUT_EN
                else if (wait_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + TMO_W'(1);
                end
`endif
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    if (ent_cnt_q == 4'd8) begin
                        ent_cnt_d = '0;
                        state_d   = S_LOAD;
                    end else begin
                        ent_cnt_d = ent_cnt_q + 4'd1;
                    end
                end
            end
`ifdef MMULT_HOST_TIMEOUT_EN
            S_ERR: state_d = S_ERR;
`endif
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        bus.in_ready   = alive_q && (state_q == S_LOAD);
        bus.mm_reset_n = alive_q && (state_q != S_RST);
        bus.mm_enable  = (state_q == S_WAIT);
        bus.A_mat      = a_q;
        bus.B_mat      = b_q;
        bus.out_valid  = (state_q == S_DRAIN);
        bus.out_data   = c_q[c_off +: 17];
        bus.out_last   = (state_q == S_DRAIN) && (ent_cnt_q == 4'd8);
        busy           = (state_q != S_LOAD);
`ifdef MMULT_HOST_TIMEOUT_EN
        err            = (state_q == S_ERR);
`else
        err            = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mmult_host.sv
// tb/tb_mmult_host.sv - directed self-checking bench for mmult_host

module tb_mmult_host;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    mmult_host_if bus();

    mmult_host #(.TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .err     (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   va [9];
    logic [7:0]   vb [9];
    int           exp_c [9];
    logic [0:71]  exp_a;
    logic [0:71]  exp_b;
    logic [0:152] exp_cmat;
    logic [16:0]  first;
    bit           en_seen = 1'b0;

    always @(posedge clk) if (bus.mm_enable === 1'b1) en_seen = 1'b1;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int sel);
        case (sel)
            0: begin
                va = '{8'h4F, 8'h7E, 8'h57, 8'h0F, 8'h14, 8'h7B, 8'h21, 8'h4C, 8'h54};
                vb = '{8'h17, 8'h28, 8'h3A, 8'h40, 8'h2F, 8'h33, 8'h6C, 8'h22, 8'h77};
            end
            1: begin
                va = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
                vb = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
            end
            2: begin
                va = '{8'hC3, 8'h01, 8'h80, 8'h7F, 8'h00, 8'hA5, 8'h5A, 8'h10, 8'hCF};
                vb = '{8'h02, 8'hCE, 8'h11, 8'h99, 8'h40, 8'h08, 8'hB0, 8'h33, 8'h01};
            end
            default: begin
                va = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
                vb = '{8'h05, 8'h0A, 8'h0F, 8'h14, 8'h19, 8'h1E, 8'h23, 8'h28, 8'h2D};
            end
        endcase
        for (int k = 0; k < 9; k++) begin
            exp_a[k*8 +: 8] = va[k];
            exp_b[k*8 +: 8] = vb[k];
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) s += int'(va[r*3+k]) * int'(vb[k*3+c]);
                exp_c[r*3+c] = s;
                exp_cmat[(r*3+c)*17 +: 17] = 17'(s);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.mm_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mm_reset_n", bus.mm_reset_n, 0);
        check("rst_mm_enable", bus.mm_enable, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_a_mat", bus.A_mat, 0);
        check("rst_b_mat", bus.B_mat, 0);
        reset_n = 1'b1;
        check("rst_release_in_ready", bus.in_ready, 0);
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_mm_reset_n", bus.mm_reset_n, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", n < 50, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load_all(input bit stray_valid);
        if (stray_valid) begin
            bus.mm_valid = 1'b1;
            bus.C_mat    = '1;
        end
        for (int k = 0; k < 18; k++) begin
            if (k == 17) check("load_busy", busy, 0);
            send_byte(k < 9 ? va[k] : vb[k-9]);
        end
        check("rst_pulse_low", bus.mm_reset_n, 0);
        check("rst_pulse_enable", bus.mm_enable, 0);
        check("rst_pulse_busy", busy, 1);
        check("rst_pulse_in_ready", bus.in_ready, 0);
        check("loaded_a", bus.A_mat, exp_a);
        check("loaded_b", bus.B_mat, exp_b);
        tick();
        check("wait_enable", bus.mm_enable, 1);
        check("wait_mm_reset_n", bus.mm_reset_n, 1);
    endtask

    task automatic respond(input int delay);
        bus.mm_valid = 1'b0;
        repeat (delay) tick();
        bus.C_mat    = exp_cmat;
        bus.mm_valid = 1'b1;
        tick();
        bus.mm_valid = 1'b0;
        bus.C_mat    = '1;
        check("drain_enable_drop", bus.mm_enable, 0);
        check("drain_out_valid", bus.out_valid, 1);
    endtask

    task automatic drain(input bit toggle, output logic [16:0] first_o);
        int          idx;
        int          cyc;
        bit          stalled;
        logic [16:0] held;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        first_o = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        while (idx < 9 && cyc < 100) begin
            bus.out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            check("drain_valid", bus.out_valid, 1);
            check("drain_in_ready", bus.in_ready, 0);
            check("drain_a_hold", bus.A_mat, exp_a);
            check("drain_b_hold", bus.B_mat, exp_b);
            if (stalled) check("stall_stable", bus.out_data, held);
            if (bus.out_valid && bus.out_ready) begin
                if (idx == 0) first_o = bus.out_data;
                check($sformatf("entry%0d", idx), bus.out_data, exp_c[idx]);
                check($sformatf("last%0d", idx), bus.out_last, idx == 8);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = bus.out_valid;
                held    = bus.out_data;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("drain_count", idx, 9);
        check("post_out_valid", bus.out_valid, 0);
        check("post_busy", busy, 0);
        check("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mm_valid  = 1'b0;
        bus.C_mat     = '0;
        bus.out_ready = 1'b0;
        #1;
        do_reset();

        // Reference vector, result after a short multiplier delay.
        set_vec(0);
        load_all(1'b0);
        respond(3);
        drain(1'b0, first);
        check("first_entry_19277", first, 17'd19277);

        // Backpressure on every other cycle.
        set_vec(1);
        load_all(1'b0);
        respond(0);
        drain(1'b1, first);

        // mm_valid high during LOAD ignored; first-WAIT-cycle result latched.
        set_vec(2);
        load_all(1'b1);
        respond(0);
        drain(1'b0, first);

        // Abort a partial load with reset, then a clean full load.
        set_vec(2);
        en_seen = 1'b0;
        for (int k = 0; k < 10; k++) send_byte(k < 9 ? va[k] : vb[k-9]);
        do_reset();
        check("abort_no_enable", en_seen, 0);
        set_vec(3);
        load_all(1'b0);
        respond(2);
        drain(1'b1, first);

        // Back-to-back operations.
        set_vec(0);
        load_all(1'b0);
        respond(1);
        drain(1'b0, first);
        check("b2b_first_19277", first, 17'd19277);
        set_vec(1);
        load_all(1'b0);
        respond(0);
        drain(1'b1, first);

        // Multiplier never answers.
        set_vec(3);
        load_all(1'b0);
`ifdef MMULT_HOST_TIMEOUT_EN
        repeat (15) tick();
        check("tmo_err_before", err, 0);
        check("tmo_enable_before", bus.mm_enable, 1);
        tick();
        check("tmo_err", err, 1);
        check("tmo_enable_off", bus.mm_enable, 0);
        check("tmo_busy", busy, 1);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("tmo_in_ready", bus.in_ready, 0);
            check("tmo_err_sticky", err, 1);
        end
        bus.in_valid = 1'b0;
        do_reset();
`else
        repeat (300) tick();
        check("notmo_enable", bus.mm_enable, 1);
        check("notmo_err", err, 0);
        check("notmo_busy", busy, 1);
        respond(0);
        drain(1'b0, first);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mmult_host.md
MMULT_HOST -- requirements
Module: mmult_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: maximum cycles spent in WAIT before the error exit (used only with MMULT_HOST_TIMEOUT_EN).
REQ-002 clk  input  1  the single clock; all logic SHALL be rising-edge.
REQ-003 reset_n  input  1  reset; it SHALL be synchronous and active-low.
REQ-004 in_valid  input  1  input byte valid.
REQ-005 in_ready  output  1  host accepts a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-006 in_data  input  8  operand byte.
REQ-007 mm_reset_n  output  1  reset to the multiplier, active-low.
REQ-008 mm_enable  output  1  start/hold to the multiplier.
REQ-009 A_mat, B_mat  output  72 each, bit order [0:71]  operand matrices to the multiplier.
REQ-010 mm_valid  input  1  multiplier result valid.
REQ-011 C_mat  input  153, bit order [0:152]  result matrix of 9 x 17-bit entries.
REQ-012 out_valid  output  1  result entry valid.
REQ-013 out_ready  input  1  downstream accepts an entry.
REQ-014 out_data  output  17  result entry.
REQ-015 out_last  output  1  high with the 9th entry.
REQ-016 busy  output  1  high in any state other than LOAD.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have the states LOAD, RST, WAIT, DRAIN and ERR.
REQ-019 LOAD: in_ready=1; accepted bytes fill A_mat[k*8 +: 8] for k=0..8, then B_mat[k*8 +: 8] for k=0..8 (row-major); accepting byte 18 SHALL move the FSM to RST.
REQ-020 RST: mm_reset_n=0 for exactly 1 cycle, then the FSM SHALL move to WAIT.
REQ-021 WAIT: mm_enable=1; on the first cycle mm_valid is sampled high, C_mat SHALL be latched into an internal 153-bit register, mm_enable SHALL drop the next cycle, and the FSM SHALL move to DRAIN.
REQ-022 DRAIN: out_valid=1 and out_data=latched[i*17 +: 17] for i=0..8; i SHALL advance only on out_valid and out_ready; out_last=1 when i=8.
REQ-023 When the i=8 transfer completes, the FSM SHALL return to LOAD with the byte and entry counters cleared.
REQ-024 Latency from the 18th accepted byte to mm_enable high SHALL be 2 cycles.
REQ-025 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD SHALL be ignored.
REQ-027 A_mat and B_mat SHALL stay constant from RST through DRAIN.
REQ-028 C entries SHALL pass through unmodified; the block SHALL perform no arithmetic on them.
REQ-029 mm_valid outside WAIT SHALL be ignored.
REQ-030 mm_valid high on the first WAIT cycle SHALL be accepted.

Reset
REQ-031 When reset_n=0 at a clock edge, all of the following SHALL hold: state=LOAD; counters=0; A_mat=B_mat=0; latched C=0; mm_reset_n=0; mm_enable=0; out_valid=0; out_last=0; err=0; busy=0; in_ready=0 during the reset cycle.
REQ-032 Reset mid-operation in any state SHALL abort the operation with no output; a partial load SHALL be discarded.
REQ-033 After reset_n returns high, mm_reset_n SHALL be 1 and in_ready SHALL be 1 on the next cycle.

Configuration
REQ-034 With macro MMULT_HOST_TIMEOUT_EN defined: a WAIT-cycle counter SHALL run; reaching TIMEOUT_CYCLES without mm_valid SHALL enter ERR.
REQ-035 In ERR: mm_enable=0 and err=1; the FSM SHALL stay in ERR until reset_n.
REQ-036 Without MMULT_HOST_TIMEOUT_EN: the timeout counter and the ERR state SHALL not be built; err SHALL be tied to 0; WAIT SHALL have no time limit.

Verification
REQ-037 Load A=4F,7E,57,0F,14,7B,21,4C,54 and B=17,28,3A,40,2F,33,6C,22,77; model returns the correct product -> first out_data=19277; 9 transfers; out_last on the 9th only.
REQ-038 Toggle out_ready 1/0 each cycle during DRAIN -> no entry lost or duplicated; out_data stable while stalled.
REQ-039 Assert reset_n low after 10 bytes, then run a full load -> mm_enable never rises for the aborted load; the next run loads all 18 new bytes correctly.
REQ-040 Model never asserts mm_valid, macro defined, TIMEOUT_CYCLES=16 -> err=1 and mm_enable=0 after 16 WAIT cycles; in_ready stays 0 until reset.
REQ-041 Model asserts mm_valid during LOAD and again on the first WAIT cycle -> the pulse during LOAD is ignored; the first-WAIT-cycle result is latched.
REQ-042 Run two back-to-back operations -> mm_reset_n low exactly 1 cycle before each WAIT; A_mat holds during DRAIN.
